// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK line levels and the
// default slave address. Used by i2c_slave and intended for i2c_master too.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2cState_e;

  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;
  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h42;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// Register-side handshake of the I2C slave: pointer, write strobe/data,
// read request/data and the busy flag.
interface i2c_slave_if;

  logic [7:0] regAddr;
  logic [7:0] regWData;
  logic       regWrite;
  logic       regRead;
  logic [7:0] regRData;
  logic       busy;

  // slave: the I2C block driving the register bus; master: the register file
  modport slave  (output regAddr, regWData, regWrite, regRead, busy, input  regRData);
  modport master (input  regAddr, regWData, regWrite, regRead, busy, output regRData);

endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one I2C line, idling high. Define
// I2C_SLAVE_FILTER_EN to add a 3-sample majority glitch filter (2 clk extra).
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic nReset,
  input  logic lineIn,
  output logic lineOut
);

  logic [1:0] syncReg;

  always_ff @(posedge clk) begin
    if (!nReset) syncReg <= 2'b11;
    else         syncReg <= {syncReg[0], lineIn};
  end

`ifdef I2C_SLAVE_FILTER_EN
  logic [1:0] histReg;
  logic       filtReg;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      histReg <= 2'b11;
      filtReg <= 1'b1;
    end else begin
      histReg <= {histReg[0], syncReg[1]};
      filtReg <= majority3(syncReg[1], histReg[0], histReg[1]);
    end
  end

  assign lineOut = filtReg;
`else
  assign lineOut = syncReg[1];
`endif

endmodule

// File: rtl/i2c_slave.sv
// I2C register-access slave (7-bit address, pointer byte then data bytes,
// auto-incrementing pointer). Optional input filter: I2C_SLAVE_FILTER_EN.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = I2C_DEFAULT_ADDR
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] regAddr,
  output logic [7:0] regWData,
  output logic       regWrite,
  output logic       regRead,
  input  logic [7:0] regRData,
  output logic       busy
);

  logic sclS, sdaS, sclPrev, sdaPrev;
  logic sclRise, sclFall, startDet, stopDet;

  i2c_line_sync sclSync (.clk(clk), .nReset(nReset), .lineIn(scl), .lineOut(sclS));
  i2c_line_sync sdaSync (.clk(clk), .nReset(nReset), .lineIn(sda), .lineOut(sdaS));

  always_ff @(posedge clk) begin
    if (!nReset) begin
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclPrev <= sclS;
      sdaPrev <= sdaS;
    end
  end

  assign sclRise  =  sclS & ~sclPrev;
  assign sclFall  = ~sclS &  sclPrev;
  assign startDet =  sclS &  sclPrev &  sdaPrev & ~sdaS;
  assign stopDet  =  sclS &  sclPrev & ~sdaPrev &  sdaS;

  i2cState_e  state;
  logic [2:0] bitCnt;
  logic [7:0] shiftReg;
  logic [7:0] rxByte;
  logic       rwBit;
  logic       ackOn;
  logic       sdaOe;
  logic       rdLoad;

  assign rxByte = {shiftReg[6:0], sdaS};

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state    <= IDLE;
      bitCnt   <= 3'd0;
      shiftReg <= 8'h00;
      rwBit    <= 1'b0;
      ackOn    <= 1'b0;
      sdaOe    <= 1'b0;
      rdLoad   <= 1'b0;
      regAddr  <= 8'h00;
      regWData <= 8'h00;
      regWrite <= 1'b0;
      regRead  <= 1'b0;
    end else begin
      regWrite <= 1'b0;
      regRead  <= 1'b0;
      rdLoad   <= regRead;
      // register file answers one clk after the request
      if (rdLoad) shiftReg <= regRData;

      if (startDet) begin
        state  <= ADDR;
        bitCnt <= 3'd0;
        ackOn  <= 1'b0;
        sdaOe  <= 1'b0;
      end else if (stopDet) begin
        state <= IDLE;
        ackOn <= 1'b0;
        sdaOe <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (sclRise) begin
              shiftReg <= rxByte;
              bitCnt   <= bitCnt + 3'd1;
              if (bitCnt == 3'd7) begin
                if (state == ADDR) begin
                  rwBit <= rxByte[0];
                  state <= (rxByte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                end else if (state == PTR) begin
                  regAddr <= rxByte;
                  state   <= PTR_ACK;
                end else begin
                  regWData <= rxByte;
                  regWrite <= 1'b1;
                  state    <= WDATA_ACK;
                end
              end
            end
          end

          // ACK slot: first falling edge pulls sda low, second one ends the slot
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (sclFall) begin
              if (!ackOn) begin
                ackOn <= 1'b1;
                sdaOe <= 1'b1;
                if (state == ADDR_ACK && rwBit) regRead <= 1'b1;
              end else begin
                ackOn  <= 1'b0;
                bitCnt <= 3'd0;
                if (state == ADDR_ACK && rwBit) begin
                  state    <= RDATA;
                  sdaOe    <= ~shiftReg[7];
                  shiftReg <= {shiftReg[6:0], 1'b0};
                end else begin
                  sdaOe <= 1'b0;
                  if (state == ADDR_ACK) begin
                    state <= PTR;
                  end else begin
                    state <= WDATA;
                    if (state == WDATA_ACK) regAddr <= regAddr + 8'd1;
                  end
                end
              end
            end
          end

          RDATA: begin
            if (sclFall) begin
              sdaOe    <= ~shiftReg[7];
              shiftReg <= {shiftReg[6:0], 1'b0};
            end
            if (sclRise) begin
              bitCnt <= bitCnt + 3'd1;
              if (bitCnt == 3'd7) state <= RDATA_ACK;
            end
          end

          RDATA_ACK: begin
            if (sclFall) sdaOe <= 1'b0;
            if (sclRise) begin
              if (sdaS == I2C_ACK) begin
                regAddr <= regAddr + 8'd1;
                regRead <= 1'b1;
                bitCnt  <= 3'd0;
                state   <= RDATA;
              end else if (sdaS == I2C_NACK) begin
                state <= IGNORE;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

  // Gating with nReset releases the line in the very cycle reset is applied
  assign sda  = (sdaOe && nReset) ? 1'b0 : 1'bz;
  assign busy = !(state inside {IDLE, ADDR, IGNORE});

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave; register strobes are checked by a
// scoreboard monitor against expectations queued by the stimulus.
`timescale 1ns/1ps
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam logic [6:0] DEV = 7'h42;
  localparam int         Q   = 8;   // clk cycles per quarter I2C bit

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nReset = 1'b0;
  logic scl    = 1'b1;
  logic sdaDrv = 1'b1;
  wire  sda;

  assign sda = sdaDrv ? 1'bz : 1'b0;
  pullup (sda);

  i2c_slave_if regBus ();

  i2c_slave #(.DEV_ADDR(DEV)) dut (
    .clk     (clk),
    .nReset  (nReset),
    .scl     (scl),
    .sda     (sda),
    .regAddr (regBus.regAddr),
    .regWData(regBus.regWData),
    .regWrite(regBus.regWrite),
    .regRead (regBus.regRead),
    .regRData(regBus.regRData),
    .busy    (regBus.busy)
  );

  // Register file stand-in: byte at address a reads as a ^ 0xFF
  always @(posedge clk) if (regBus.regRead) regBus.regRData <= regBus.regAddr ^ 8'hFF;

  int tests = 0;
  int fails = 0;
  int dutDriveCnt = 0;
  logic watchSda = 1'b0;
  logic [15:0] expWr[$];
  logic [7:0]  expRd[$];
  logic [7:0]  modelPtr = 8'h00;
  logic [15:0] wrPop;
  logic [7:0]  rdPop;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (regBus.regWrite) begin
      if (expWr.size() == 0) begin
        tests++; fails++;
        $display("FAIL regWrite_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                 regBus.regAddr, regBus.regWData);
      end else begin
        wrPop = expWr.pop_front();
        check("regWrite_addr_data", {regBus.regAddr, regBus.regWData}, wrPop);
      end
    end
    if (regBus.regRead) begin
      if (expRd.size() == 0) begin
        tests++; fails++;
        $display("FAIL regRead_unexpected: got addr 0x%0h, expected no read", regBus.regAddr);
      end else begin
        rdPop = expRd.pop_front();
        check("regRead_addr", regBus.regAddr, rdPop);
      end
    end
    if (regBus.regWrite && regBus.regRead) begin
      tests++; fails++;
      $display("FAIL strobe_overlap: got regWrite=1 regRead=1, expected at most one");
    end
    if (watchSda && sdaDrv && sda === 1'b0) dutDriveCnt++;
  end

  task automatic q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bitIo(input logic b, output logic s);
    sdaDrv = b; q();
    scl = 1'b1; q();
    s = sda;    q();
    scl = 1'b0; q();
  endtask

  task automatic startCond();
    sdaDrv = 1'b1; q();
    scl    = 1'b1; q();
    sdaDrv = 1'b0; q();
    scl    = 1'b0; q();
  endtask

  task automatic stopCond();
    sdaDrv = 1'b0; q();
    scl    = 1'b1; q();
    sdaDrv = 1'b1; q(); q();
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bitIo(b[i], s);
    bitIo(1'b1, ack);
  endtask

  task automatic readByte(input logic masterAck, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bitIo(1'b1, s);
      d[i] = s;
    end
    bitIo(masterAck, s);
  endtask

  task automatic writeTxn(input logic [7:0] ptr, input logic [7:0] data[$]);
    logic a;
    startCond();
    sendByte({DEV, 1'b0}, a); check("waddr_ack", a, I2C_ACK);
    check("busy_addressed", regBus.busy, 1);
    sendByte(ptr, a);         check("ptr_ack", a, I2C_ACK);
    modelPtr = ptr;
    foreach (data[i]) begin
      expWr.push_back({modelPtr, data[i]});
      sendByte(data[i], a);   check("wdata_ack", a, I2C_ACK);
      modelPtr = modelPtr + 8'd1;
    end
    stopCond(); q();
    check("regAddr_after_write", regBus.regAddr, modelPtr);
    check("busy_after_stop", regBus.busy, 0);
  endtask

  task automatic readTxn(input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] d;
    startCond();
    sendByte({DEV, 1'b0}, a); check("waddr_ack", a, I2C_ACK);
    sendByte(ptr, a);         check("ptr_ack", a, I2C_ACK);
    modelPtr = ptr;
    startCond();
    expRd.push_back(modelPtr);
    sendByte({DEV, 1'b1}, a); check("raddr_ack", a, I2C_ACK);
    for (int i = 0; i < n; i++) begin
      if (i != n - 1) expRd.push_back(modelPtr + 8'd1);
      readByte((i == n - 1) ? I2C_NACK : I2C_ACK, d);
      check("rdata_byte", d, modelPtr ^ 8'hFF);
      if (i != n - 1) modelPtr = modelPtr + 8'd1;
    end
    check("busy_after_nack", regBus.busy, 0);
    stopCond(); q();
    check("regAddr_after_read", regBus.regAddr, modelPtr);
  endtask

  initial begin
    logic a, s;
    logic [7:0] wq[$];

    repeat (5) @(negedge clk);
    check("rst_regAddr",  regBus.regAddr,  0);
    check("rst_regWData", regBus.regWData, 0);
    check("rst_regWrite", regBus.regWrite, 0);
    check("rst_regRead",  regBus.regRead,  0);
    check("rst_busy",     regBus.busy,     0);
    check("rst_sda",      sda,             1);
    nReset = 1'b1;
    q();

    // Pointer write then two data bytes
    wq = '{8'hAA, 8'hBB};
    writeTxn(8'h50, wq);

    // Pointer, repeated START, three reads ending in NACK
    readTxn(8'h10, 3);

    // Foreign address: never ACKed, line never pulled by the slave
    watchSda = 1'b1;
    startCond();
    sendByte({7'h43, 1'b0}, a); check("foreign_addr_nack", a, I2C_NACK);
    check("busy_foreign", regBus.busy, 0);
    sendByte(8'h5A, a);         check("foreign_data_nack", a, I2C_NACK);
    stopCond();
    watchSda = 1'b0;
    check("foreign_sda_driven_cycles", dutDriveCnt, 0);

    // Pointer wrap 0xFF -> 0x00
    wq = '{8'h11, 8'h22};
    writeTxn(8'hFF, wq);

    // START after 4 data bits: no write, new address phase ACKed
    startCond();
    sendByte({DEV, 1'b0}, a); check("abort_addr_ack", a, I2C_ACK);
    sendByte(8'h30, a);       check("abort_ptr_ack", a, I2C_ACK);
    for (int i = 0; i < 4; i++) bitIo(1'b0, s);
    startCond();
    sendByte({DEV, 1'b0}, a); check("restart_addr_ack", a, I2C_ACK);
    sendByte(8'h60, a);       check("restart_ptr_ack", a, I2C_ACK);
    stopCond(); q();
    check("regAddr_after_abort", regBus.regAddr, 8'h60);

    // Reset while the slave drives a 0 data bit (0x80 reads as 0x7F)
    startCond();
    sendByte({DEV, 1'b0}, a); check("rst_test_addr_ack", a, I2C_ACK);
    sendByte(8'h80, a);       check("rst_test_ptr_ack", a, I2C_ACK);
    startCond();
    expRd.push_back(8'h80);
    sendByte({DEV, 1'b1}, a); check("rst_test_raddr_ack", a, I2C_ACK);
    check("rdata_msb_driven_low", sda, 0);
    nReset = 1'b0;
    @(negedge clk);
    check("sda_released_in_reset", sda, 1);
    check("regAddr_in_reset", regBus.regAddr, 0);
    nReset = 1'b1;
    for (int i = 0; i < 9; i++) bitIo(1'b1, s);
    stopCond(); q();
    check("regAddr_after_reset", regBus.regAddr, 0);
    check("busy_after_reset", regBus.busy, 0);

    // Randomized write/read-back transactions
    for (int t = 0; t < 6; t++) begin
      logic [7:0] p;
      int n;
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 3);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
      $display("[TB] random txn %0d: ptr 0x%0h, %0d bytes", t, p, n);
      writeTxn(p, wq);
      readTxn(p, n);
    end

    repeat (20) @(negedge clk);
    check("pending_writes", expWr.size(), 0);
    check("pending_reads",  expRd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h42, the 7-bit bus address the block responds to.
REQ-002 SHALL have input clk, 1 bit: system clock; all logic rising-edge on clk.
REQ-003 SHALL have input nReset, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have input scl, 1 bit: I2C clock (no clock stretching).
REQ-005 SHALL have inout sda, 1 bit: I2C data, open-drain (drives 0 or Z only).
REQ-006 SHALL have output regAddr, 8 bits: current register pointer.
REQ-007 SHALL have output regWData, 8 bits: received data byte.
REQ-008 SHALL have output regWrite, 1 bit: one-clk strobe, regWData valid for regAddr.
REQ-009 SHALL have output regRead, 1 bit: one-clk request for the byte at regAddr.
REQ-010 SHALL have input regRData, 8 bits: read data, valid the clk after regRead.
REQ-011 SHALL have output busy, 1 bit: high while addressed (ADDR_ACK through end of transfer).

Function
REQ-012 SHALL pass scl/sda through 2-flop synchronizers; all edge detection uses synchronized values.
REQ-013 SHALL detect START as sda falling while scl high, and STOP as sda rising while scl high.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-015 SHALL sample sda on scl rising edges, shifting MSB first; bit counter 0..7.
REQ-016 START from any state SHALL go to ADDR, clear the bit counter and release sda within 1 clk; regAddr is preserved.
REQ-017 STOP from any state SHALL go to IDLE and release sda; regAddr is preserved.
REQ-018 ADDR: after 8 bits, addr[7:1]==DEV_ADDR -> ADDR_ACK; mismatch -> IGNORE (sda never driven until next START/STOP).
REQ-019 ADDR_ACK SHALL drive sda low from the next scl falling edge to the following scl falling edge.
REQ-020 After ADDR_ACK, R/W=0 SHALL enter PTR; R/W=1 SHALL enter RDATA and pulse regRead on the scl falling edge that starts the ACK bit.
REQ-021 PTR: received byte SHALL load regAddr; then PTR_ACK (ACK driven as REQ-019), then WDATA.
REQ-022 WDATA: on the 8th-bit scl rising edge, regWData<=byte and regWrite pulses 1 clk with the pre-increment regAddr; then WDATA_ACK ACK; regAddr increments at the end of the ACK.
REQ-023 RDATA: the shift register SHALL load regRData 1 clk after regRead; each bit SHALL be presented on scl falling edges (1=Z, 0=low); then RDATA_ACK releases sda.
REQ-024 RDATA_ACK: master ACK (sda low at scl rise) SHALL increment regAddr, pulse regRead and return to RDATA; NACK SHALL go to IGNORE.
REQ-025 regAddr increment SHALL wrap 8'hFF -> 8'h00.
REQ-026 A repeated START after PTR_ACK SHALL keep the loaded pointer for the following read.
REQ-027 regWrite and regRead SHALL never assert in the same clk.

Reset
REQ-028 With nReset low at a clk edge: state=IDLE, sda released, regAddr=0, regWData=0, regWrite=0, regRead=0, busy=0, synchronizers set to 1.
REQ-029 Reset mid-transfer SHALL release sda in the same cycle; the block resumes only at the next START.

Configuration
REQ-030 With I2C_SLAVE_FILTER_EN defined, a 3-sample majority filter SHALL follow each synchronizer (2 clk of extra latency); without it, synchronizer outputs are used directly.

Structure
REQ-031 State enum, I2C_ACK/I2C_NACK constants and the default-address constant SHALL live in shared package i2c_pkg, also usable by i2c_master.
REQ-032 Synchronizer plus optional filter SHALL be sub-module i2c_line_sync, instantiated once per line.

Verification
REQ-033 Write 0x50 then 0xAA,0xBB to DEV_ADDR -> ACK on all 4 bytes; regWrite at addr 0x50=0xAA, 0x51=0xBB; regAddr=0x52 after STOP.
REQ-034 Ptr 0x10, repeated START, read 3 bytes ACK,ACK,NACK with regRData=addr^0xFF -> bus reads 0xEF,0xEE,0xED; 3 regRead pulses; IGNORE after NACK.
REQ-035 Address 0x43 with DEV_ADDR 0x42 -> sda never driven low by DUT; no strobes; busy=0.
REQ-036 Ptr 0xFF, write 2 bytes -> writes to 0xFF and 0x00.
REQ-037 START mid-WDATA after 4 bits -> no regWrite; new address phase ACKed normally.
REQ-038 nReset low during RDATA driving 0 -> sda Z next clk; regAddr=0; no strobes until next START.
